// File: rtl/painel_rolagem_mux_if.sv
// Bus between the scrolling-display mux and its environment: tick/pause inputs and the
// registered display outputs. clk/rst are kept as plain ports on the module.
interface painel_rolagem_mux_if;
    logic       tick_scan;    // 1-cycle pulse, advances the active digit
    logic       tick_scroll;  // 1-cycle pulse, advances the scroll pointer
    logic       pause;        // level, freezes scrolling
    logic [3:0] an;           // digit anodes, active-low, one-hot-low
    logic [6:0] seg;          // segments {g,f,e,d,c,b,a}, active-low
    logic [4:0] pos;          // scroll pointer
    logic       wrap;         // 1-cycle pulse on pointer wrap

    modport master (
        output tick_scan, tick_scroll, pause,
        input  an, seg, pos, wrap
    );

    modport slave (
        input  tick_scan, tick_scroll, pause,
        output an, seg, pos, wrap
    );
endinterface

// File: rtl/painel_rolagem_mux.sv
// Scrolling-message driver for a 4-digit multiplexed 7-segment display.
// tick_scan / tick_scroll are enable pulses in the clk domain, never clocks.
// Optional feature: define PAINEL_BLINK_EN to blink the display while the
// start of the message is held after a wrap.
module painel_rolagem_mux #(
    parameter int unsigned MSG_LEN  = 16,  // 4..32
    parameter int unsigned N_DIG    = 4,   // fixed at 4
    parameter int unsigned HOLD_TKS = 3    // 0 disables HOLD
) (
    input logic                 clk,
    input logic                 rst,
    painel_rolagem_mux_if.slave bus
);

    typedef enum logic [1:0] {StRun, StPause, StHold} state_e;

    localparam logic [4:0] PosLast  = 5'(MSG_LEN - 1);
    localparam logic [5:0] MsgLen6  = 6'(MSG_LEN);
    localparam logic [1:0] DigLast  = 2'(N_DIG - 1);
    localparam logic [7:0] HoldInit = 8'(HOLD_TKS);

    // Message ROM, 5-bit character codes (0-9 digits, 10-25 A-P, 31 blank).
    function automatic logic [4:0] rom_code(input logic [4:0] idx);
        logic [4:0] c;
        case (idx)
            5'd0:  c = 5'd17;  // H
            5'd1:  c = 5'd14;  // E
            5'd2:  c = 5'd21;  // L
            5'd3:  c = 5'd21;  // L
            5'd4:  c = 5'd24;  // O
            5'd5:  c = 5'd31;
            5'd6:  c = 5'd0;
            5'd7:  c = 5'd1;
            5'd8:  c = 5'd2;
            5'd9:  c = 5'd3;
            5'd10: c = 5'd4;
            5'd11: c = 5'd5;
            5'd12: c = 5'd6;
            5'd13: c = 5'd7;
            5'd14: c = 5'd8;
            5'd15: c = 5'd9;
            5'd16: c = 5'd31;
            5'd17: c = 5'd25;  // P
            5'd18: c = 5'd10;  // A
            5'd19: c = 5'd18;  // I
            5'd20: c = 5'd23;  // N
            5'd21: c = 5'd14;  // E
            5'd22: c = 5'd21;  // L
            5'd23: c = 5'd31;
            5'd24: c = 5'd10;
            5'd25: c = 5'd11;
            5'd26: c = 5'd12;
            5'd27: c = 5'd13;
            5'd28: c = 5'd15;
            5'd29: c = 5'd16;
            5'd30: c = 5'd19;
            default: c = 5'd20;
        endcase
        return c;
    endfunction

    // Character code to active-low segment pattern; codes 26..31 are blank.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] p;  // active-high {g..a}
        case (code)
            5'd0:  p = 7'h3F;
            5'd1:  p = 7'h06;
            5'd2:  p = 7'h5B;
            5'd3:  p = 7'h4F;
            5'd4:  p = 7'h66;
            5'd5:  p = 7'h6D;
            5'd6:  p = 7'h7D;
            5'd7:  p = 7'h07;
            5'd8:  p = 7'h7F;
            5'd9:  p = 7'h6F;
            5'd10: p = 7'h77;
            5'd11: p = 7'h7C;
            5'd12: p = 7'h39;
            5'd13: p = 7'h5E;
            5'd14: p = 7'h79;
            5'd15: p = 7'h71;
            5'd16: p = 7'h3D;
            5'd17: p = 7'h76;
            5'd18: p = 7'h30;
            5'd19: p = 7'h1E;
            5'd20: p = 7'h75;
            5'd21: p = 7'h38;
            5'd22: p = 7'h37;
            5'd23: p = 7'h54;
            5'd24: p = 7'h5C;
            5'd25: p = 7'h73;
            default: p = 7'h00;
        endcase
        return ~p;
    endfunction

    state_e     state_q, state_d;
    logic [4:0] pos_q, pos_d;
    logic [1:0] dig_q, dig_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       wrap_q, wrap_d;
    logic [5:0] char_sum;
    logic [4:0] char_idx;

`ifdef PAINEL_BLINK_EN
    logic blink_q, blink_d;
`endif

    // Scroll FSM next state; only a tick_scroll can move it.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        wrap_d  = 1'b0;
        if (bus.tick_scroll) begin
            unique case (state_q)
                StRun: begin
                    if (bus.pause) begin
                        state_d = StPause;
                    end else if (pos_q == PosLast) begin
                        pos_d  = 5'd0;
                        wrap_d = 1'b1;
                        if (HoldInit != 8'd0) begin
                            hold_d  = HoldInit;
                            state_d = StHold;
                        end
                    end else begin
                        pos_d = pos_q + 5'd1;
                    end
                end
                StPause: begin
                    // Pointer only moves on the tick after leaving PAUSE.
                    if (!bus.pause) state_d = StRun;
                end
                StHold: begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q == 8'd1) state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Digit scanner and registered anode/segment next values.
    always_comb begin
        dig_d = dig_q;
        if (bus.tick_scan) dig_d = (dig_q == DigLast) ? 2'd0 : dig_q + 2'd1;
        // (pos + 3 - dig) mod MSG_LEN: sum < 2*MSG_LEN, so one subtract suffices.
        char_sum = {1'b0, pos_q} + {4'd0, 2'd3 - dig_q};
        char_idx = (char_sum >= MsgLen6) ? 5'(char_sum - MsgLen6) : char_sum[4:0];
        an_d     = ~(4'b0001 << dig_q);
        seg_d    = glyph(rom_code(char_idx));
`ifdef PAINEL_BLINK_EN
        if (state_q == StHold && blink_q) seg_d = 7'h7F;
`endif
    end

`ifdef PAINEL_BLINK_EN
    // Blink phase toggles once per full scan pass and restarts on HOLD exit.
    always_comb begin
        blink_d = blink_q;
        if (bus.tick_scan && dig_q == DigLast) blink_d = ~blink_q;
        if (state_q == StHold && state_d != StHold) blink_d = 1'b0;
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pos_q   <= 5'd0;
            dig_q   <= 2'd0;
            hold_q  <= 8'd0;
            an_q    <= 4'b1110;
            seg_q   <= 7'h7F;
            wrap_q  <= 1'b0;
`ifdef PAINEL_BLINK_EN
            blink_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dig_q   <= dig_d;
            hold_q  <= hold_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            wrap_q  <= wrap_d;
`ifdef PAINEL_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_painel_rolagem_mux.sv
// Bench for painel_rolagem_mux: two instances (HOLD_TKS=3 and HOLD_TKS=0) share stimulus
// and are compared against a cycle-level behavioural model of the display.
module tb_painel_rolagem_mux;

    localparam int MSG = 16;
    localparam int M_RUN = 0, M_PAUSE = 1, M_HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    painel_rolagem_mux_if bus_h3 ();
    painel_rolagem_mux_if bus_h0 ();

    painel_rolagem_mux #(.MSG_LEN(16), .N_DIG(4), .HOLD_TKS(3)) dut_h3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_h3)
    );

    painel_rolagem_mux #(.MSG_LEN(16), .N_DIG(4), .HOLD_TKS(0)) dut_h0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_h0)
    );

    logic [3:0] an_o [2];
    logic [6:0] seg_o [2];
    logic [4:0] pos_o [2];
    logic       wrap_o [2];
    assign an_o[0] = bus_h3.an;   assign an_o[1] = bus_h0.an;
    assign seg_o[0] = bus_h3.seg; assign seg_o[1] = bus_h0.seg;
    assign pos_o[0] = bus_h3.pos; assign pos_o[1] = bus_h0.pos;
    assign wrap_o[0] = bus_h3.wrap; assign wrap_o[1] = bus_h0.wrap;

    // Message and glyph tables (active-high patterns for codes 0..25).
    logic [4:0] rom [32] = '{17, 14, 21, 21, 24, 31, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                            31, 25, 10, 18, 23, 14, 21, 31, 10, 11, 12, 13, 15, 16, 19, 20};
    logic [6:0] pat [26] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                            7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,
                            7'h30, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h5C, 7'h73};

    function automatic logic [6:0] glyph(input int code);
        if (code > 25) return 7'h7F;
        return ~pat[code];
    endfunction

    // Model state per instance.
    int         hold_tks [2] = '{3, 0};
    int         m_st [2], m_pos [2], m_dig [2], m_hold [2];
    logic [3:0] e_an [2];
    logic [6:0] e_seg [2];
    logic       e_wrap [2];

    int n_checks = 0;
    int n_fail = 0;

    task automatic model_step(input bit sc, input bit sr, input bit p, input bit r);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_st[k] = M_RUN; m_pos[k] = 0; m_dig[k] = 0; m_hold[k] = 0;
                e_an[k] = 4'hE; e_seg[k] = 7'h7F; e_wrap[k] = 1'b0;
            end else begin
                // Displayed frame reflects the pointer and digit in force before this edge.
                e_an[k] = 4'hF;
                e_an[k][m_dig[k]] = 1'b0;
                e_seg[k] = glyph(rom[(m_pos[k] + 3 - m_dig[k]) % MSG]);
                e_wrap[k] = 1'b0;
                if (sr) begin
                    if (m_st[k] == M_RUN) begin
                        if (p) m_st[k] = M_PAUSE;
                        else begin
                            m_pos[k] = (m_pos[k] + 1) % MSG;
                            if (m_pos[k] == 0) begin
                                e_wrap[k] = 1'b1;
                                if (hold_tks[k] > 0) begin
                                    m_hold[k] = hold_tks[k];
                                    m_st[k] = M_HOLD;
                                end
                            end
                        end
                    end else if (m_st[k] == M_PAUSE) begin
                        if (!p) m_st[k] = M_RUN;
                    end else begin
                        m_hold[k] = m_hold[k] - 1;
                        if (m_hold[k] == 0) m_st[k] = M_RUN;
                    end
                end
                if (sc) m_dig[k] = (m_dig[k] + 1) % 4;
            end
        end
    endtask

    // Drive one clock cycle of stimulus, advance the model, settle past the edge.
    task automatic cycle(input bit sc, input bit sr, input bit p, input bit r);
        rst = r;
        bus_h3.tick_scan = sc; bus_h3.tick_scroll = sr; bus_h3.pause = p;
        bus_h0.tick_scan = sc; bus_h0.tick_scroll = sr; bus_h0.pause = p;
        @(posedge clk);
        model_step(sc, sr, p, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (an_o[k] !== 4'b1110 || seg_o[k] !== 7'h7F || pos_o[k] !== 5'd0
                || wrap_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got an=%b seg=%h pos=%0d wrap=%b want 1110/7f/0/0",
                         k, an_o[k], seg_o[k], pos_o[k], wrap_o[k]);
            end
        end
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (an_o[k] !== 4'b1110 || seg_o[k] !== glyph(rom[3])) begin
                n_fail++;
                $display("FAIL reset_first_frame dut%0d: got an=%b seg=%h want 1110/%h",
                         k, an_o[k], seg_o[k], glyph(rom[3]));
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_an;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            want_an = 4'hF;
            want_an[i % 4] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (an_o[k] !== want_an || seg_o[k] !== glyph(rom[3 - (i % 4)])) begin
                    n_fail++;
                    $display("FAIL scan step%0d dut%0d: got an=%b seg=%h want %b/%h", i, k,
                             an_o[k], seg_o[k], want_an, glyph(rom[3 - (i % 4)]));
                end
            end
        end
    endtask

    task automatic test_scroll_wrap();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 0);
            n_checks++;
            if (pos_o[1] !== 5'((i + 1) % 16) || wrap_o[1] !== (i == 15)) begin
                n_fail++;
                $display("FAIL scroll tick%0d: got pos=%0d wrap=%b want pos=%0d wrap=%b",
                         i + 1, pos_o[1], wrap_o[1], (i + 1) % 16, (i == 15));
            end
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (wrap_o[1] !== 1'b0 || wrap_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pulse_width: got %b/%b want 0/0", wrap_o[0], wrap_o[1]);
        end
    endtask

    task automatic test_hold();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0);
        n_checks++;
        if (wrap_o[0] !== 1'b1 || pos_o[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL hold_wrap: got wrap=%b pos=%0d want 1/0", wrap_o[0], pos_o[0]);
        end
        for (int j = 0; j < 3; j++) begin
            cycle(0, 1, 1, 0);
            n_checks++;
            if (pos_o[0] !== 5'd0) begin
                n_fail++;
                $display("FAIL hold tick%0d: got pos=%0d want 0", j + 1, pos_o[0]);
            end
        end
        cycle(0, 1, 0, 0);
        n_checks++;
        if (pos_o[0] !== 5'd1) begin
            n_fail++;
            $display("FAIL hold_release: got pos=%0d want 1", pos_o[0]);
        end
        n_checks++;
        if (pos_o[1] !== 5'(m_pos[1])) begin
            n_fail++;
            $display("FAIL hold_nohold_dut: got pos=%0d want %0d", pos_o[1], m_pos[1]);
        end
    endtask

    task automatic test_pause();
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        for (int j = 0; j < 5; j++) begin
            cycle(0, 1, 1, 0);
            n_checks++;
            if (pos_o[0] !== 5'd2) begin
                n_fail++;
                $display("FAIL pause tick%0d: got pos=%0d want 2", j + 1, pos_o[0]);
            end
        end
        // Level changes between ticks must not move anything.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        n_checks++;
        if (pos_o[0] !== 5'd2) begin
            n_fail++;
            $display("FAIL pause_exit_tick: got pos=%0d want 2", pos_o[0]);
        end
        cycle(0, 1, 0, 0);
        n_checks++;
        if (pos_o[0] !== 5'd3) begin
            n_fail++;
            $display("FAIL pause_resume: got pos=%0d want 3", pos_o[0]);
        end
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        n_checks++;
        if (pos_o[0] !== 5'd0 || wrap_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_wrap: got pos=%0d wrap=%b want 0/1", pos_o[0], wrap_o[0]);
        end
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (an_o[k] !== 4'b0111 || seg_o[k] !== glyph(rom[0])) begin
                n_fail++;
                $display("FAIL simul_frame dut%0d: got an=%b seg=%h want 0111/%h",
                         k, an_o[k], seg_o[k], glyph(rom[0]));
            end
        end
    endtask

    task automatic test_random();
        bit p = 1'b0;
        bit sc, sr, r;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) p = ~p;
            sc = ($urandom_range(0, 1) == 0);
            sr = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cycle(sc, sr, p, r);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (an_o[k] !== e_an[k] || seg_o[k] !== e_seg[k]
                    || pos_o[k] !== 5'(m_pos[k]) || wrap_o[k] !== e_wrap[k]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d dut%0d: got an=%b seg=%h pos=%0d wrap=%b want %b/%h/%0d/%b",
                             i, k, an_o[k], seg_o[k], pos_o[k], wrap_o[k],
                             e_an[k], e_seg[k], m_pos[k], e_wrap[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_scroll_wrap();
        test_hold();
        test_pause();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
